// File: rtl/cflog_writer.sv
// Control-flow log producer: captures out-of-line fetch transfers from inside the executable
// region as (src,dst) pairs, buffers them, and drains them word by word into the LOG region.
module cflog_writer #(
  parameter logic [15:0] LOG_BASE   = 16'h01B0,
  parameter logic [15:0] LOG_SIZE   = 16'h0080,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        puc_rst,
  input  logic [15:0] pc,
  input  logic        fetch,
  input  logic [15:0] ER_min,
  input  logic [15:0] ER_max,
  input  logic        flush_ack,
  output logic        log_wr_en,
  output logic [15:0] log_addr,
  output logic [15:0] log_wdata,
  output logic        flush_req,
  output logic        stall_cpu,
  output logic        overflow,
  output logic [15:0] log_ptr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WR_SRC, WR_DST, WAIT_FLUSH} state_t;

  state_t          state_q;
  logic [15:0]     ptr_q;
  logic [15:0]     ptr_inc;
  logic [15:0]     last_pc_q;
  logic            last_valid_q;
  logic            overflow_q;
  logic [15:0]     src_q [FIFO_DEPTH];
  logic [15:0]     dst_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic [15:0]     seq2, seq4, seq6;
  logic            in_er, is_seq, evt, full, pop, push, drop;

  // Event detection in the fetch cycle; the +2/+4/+6 sums wrap at 16 bits
  assign seq2   = last_pc_q + 16'd2;
  assign seq4   = last_pc_q + 16'd4;
  assign seq6   = last_pc_q + 16'd6;
  assign in_er  = (last_pc_q >= ER_min) && (last_pc_q <= ER_max);
  assign is_seq = (pc == seq2) || (pc == seq4) || (pc == seq6);
  assign evt    = fetch && last_valid_q && in_er && !is_seq;

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = (state_q == WR_DST);
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      last_valid_q <= 1'b0;
    end else begin
      if (fetch) last_valid_q <= 1'b1;
      if (push)  wr_ptr_q     <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q     <= rd_ptr_q + 1'b1;
      if (drop)  overflow_q   <= 1'b1;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q and last_valid_q
  always_ff @(posedge clk) begin
    if (fetch) last_pc_q <= pc;
    if (push) begin
      src_q[wr_ptr_q] <= last_pc_q;
      dst_q[wr_ptr_q] <= pc;
    end
  end

  assign ptr_inc = ptr_q + 16'd1;

  // Drain FSM; a pair is only started with room for both words, so it never straddles a flush
  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE:       if (count_q != '0) state_q <= WR_SRC;
        WR_SRC: begin
          ptr_q   <= ptr_inc;
          state_q <= WR_DST;
        end
        WR_DST: begin
          ptr_q <= ptr_inc;
          if (ptr_inc == LOG_SIZE)  state_q <= WAIT_FLUSH;
          else if (count_d != '0)   state_q <= WR_SRC;
          else                      state_q <= IDLE;
        end
        WAIT_FLUSH: if (flush_ack) begin
          ptr_q   <= '0;
          state_q <= IDLE;
        end
        default:    state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    log_wr_en = 1'b0;
    log_wdata = '0;
    case (state_q)
      WR_SRC: begin
        log_wr_en = 1'b1;
        log_wdata = src_q[rd_ptr_q];
      end
      WR_DST: begin
        log_wr_en = 1'b1;
        log_wdata = dst_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  assign log_addr  = LOG_BASE + {ptr_q[14:0], 1'b0};
  assign flush_req = (state_q == WAIT_FLUSH);
  assign stall_cpu = flush_req | full;
  assign overflow  = overflow_q;
  assign log_ptr   = ptr_q;

endmodule

// File: tb/tb_cflog_writer.sv
// Directed bench for cflog_writer: drives fetch sequences and checks LOG writes, flush and overflow.
module tb_cflog_writer;

  logic        clk = 1'b0;
  logic        puc_rst, fetch, flush_ack;
  logic [15:0] pc, ER_min, ER_max;
  logic        log_wr_en, flush_req, stall_cpu, overflow;
  logic [15:0] log_addr, log_wdata, log_ptr;

  cflog_writer dut (
    .clk(clk), .puc_rst(puc_rst), .pc(pc), .fetch(fetch),
    .ER_min(ER_min), .ER_max(ER_max), .flush_ack(flush_ack),
    .log_wr_en(log_wr_en), .log_addr(log_addr), .log_wdata(log_wdata),
    .flush_req(flush_req), .stall_cpu(stall_cpu), .overflow(overflow), .log_ptr(log_ptr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] wa [1024];
  logic [15:0] wd [1024];
  int nw = 0;

  always @(negedge clk) begin
    if (log_wr_en === 1'b1 && nw < 1024) begin
      wa[nw] = log_addr;
      wd[nw] = log_wdata;
      nw++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [15:0] a);
    pc    = a;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
  endtask

  task automatic fetch_wait(input logic [15:0] a);
    do_fetch(a);
    repeat (3) tick();
  endtask

  int nw0, nw1;

  initial begin
    puc_rst = 1'b1; fetch = 1'b0; flush_ack = 1'b0; pc = '0;
    ER_min = 16'hE000; ER_max = 16'hE0FF;
    repeat (2) tick();
    check("rst_wr_en",   log_wr_en, 0);
    check("rst_addr",    log_addr,  16'h01B0);
    check("rst_wdata",   log_wdata, 0);
    check("rst_flush",   flush_req, 0);
    check("rst_stall",   stall_cpu, 0);
    check("rst_ovf",     overflow,  0);
    check("rst_ptr",     log_ptr,   0);
    puc_rst = 1'b0;
    tick();

    // Sequential fetches only
    fetch_wait(16'hE000); fetch_wait(16'hE002); fetch_wait(16'hE004);
    fetch_wait(16'hE00A); fetch_wait(16'hE010);
    check("seq_no_wr", nw, 0);
    check("seq_ptr",   log_ptr, 0);

    // Jump E010 -> E080, cycle-exact latency
    pc = 16'hE080; fetch = 1'b1;
    check("lat_N_wr", log_wr_en, 0);
    tick(); fetch = 1'b0;
    check("lat_N1_wr", log_wr_en, 0);
    tick();
    check("lat_N2_wr",   log_wr_en, 1);
    check("lat_N2_addr", log_addr,  16'h01B0);
    check("lat_N2_data", log_wdata, 16'hE010);
    tick();
    check("lat_N3_wr",   log_wr_en, 1);
    check("lat_N3_addr", log_addr,  16'h01B2);
    check("lat_N3_data", log_wdata, 16'hE080);
    tick();
    check("lat_N4_wr",    log_wr_en, 0);
    check("lat_N4_ptr",   log_ptr,   2);
    check("idle_addr",    log_addr,  16'h01B4);
    check("idle_wdata",   log_wdata, 0);

    // E080->E0F0 jump, E0F0->C000 exit, C000->E000 source outside
    fetch_wait(16'hE0F0); fetch_wait(16'hC000); fetch_wait(16'hE000);
    check("exit_cnt",  nw, 6);
    check("exit_src",  wd[4], 16'hE0F0);
    check("exit_dst",  wd[5], 16'hC000);
    check("exit_addr", wa[5], 16'h01BA);
    check("exit_ptr",  log_ptr, 6);

    // Empty ER, then 16-bit wrap of the sequential window
    ER_min = 16'hE100; ER_max = 16'hE0FF;
    fetch_wait(16'hE050);
    check("empty_er", nw, 6);
    ER_min = 16'hFFF0; ER_max = 16'hFFFF;
    fetch_wait(16'hFFFE); fetch_wait(16'h0000);
    check("wrap_seq", nw, 6);

    // Inclusive ER bounds
    ER_min = 16'hE000; ER_max = 16'hE0FE;
    fetch_wait(16'hE0FE); fetch_wait(16'hD000);
    check("er_max_incl", nw, 8);
    check("er_max_dst",  wd[7], 16'hD000);
    fetch_wait(16'hE000); fetch_wait(16'hE100);
    check("er_min_incl", nw, 10);
    check("er_min_src",  wd[8], 16'hE000);
    check("er_min_ptr",  log_ptr, 10);

    // Fill the LOG from a fresh reset
    ER_max = 16'hE0FF;
    puc_rst = 1'b1; tick(); puc_rst = 1'b0;
    nw0 = nw;
    fetch_wait(16'hE000);
    check("first_fetch", nw - nw0, 0);
    for (int k = 1; k <= 64; k++) fetch_wait((k % 2) ? 16'hE020 : 16'hE000);
    check("full_cnt",   nw - nw0, 128);
    check("full_ptr",   log_ptr, 16'h0080);
    check("full_flush", flush_req, 1);
    check("full_stall", stall_cpu, 1);
    check("full_laddr", wa[nw-1], 16'h02AE);
    check("full_ldata", wd[nw-1], 16'hE000);
    fetch_wait(16'hE020);
    check("held_cnt",   nw - nw0, 128);
    flush_ack = 1'b1; tick(); flush_ack = 1'b0;
    check("ack_ptr",    log_ptr, 0);
    check("ack_flush",  flush_req, 0);
    repeat (4) tick();
    check("post_cnt",   nw - nw0, 130);
    check("post_addr0", wa[nw0+128], 16'h01B0);
    check("post_data0", wd[nw0+128], 16'hE000);
    check("post_addr1", wa[nw0+129], 16'h01B2);
    check("post_data1", wd[nw0+129], 16'hE020);
    flush_ack = 1'b1; tick(); flush_ack = 1'b0;
    check("stray_ack",  log_ptr, 2);

    // Overflow while a flush is pending
    for (int k = 1; k <= 63; k++) fetch_wait((k % 2) ? 16'hE000 : 16'hE020);
    check("full2_flush", flush_req, 1);
    for (int k = 1; k <= 4; k++) fetch_wait((k % 2) ? 16'hE020 : 16'hE000);
    check("fifo4_stall", stall_cpu, 1);
    check("fifo4_ovf",   overflow, 0);
    fetch_wait(16'hE020);
    check("ovf_set",     overflow, 1);
    nw1 = nw;
    flush_ack = 1'b1; tick(); flush_ack = 1'b0;
    repeat (12) tick();
    check("drain_cnt",   nw - nw1, 8);
    check("drain_d0",    wd[nw1],   16'hE000);
    check("drain_d2",    wd[nw1+2], 16'hE020);
    check("drain_a7",    wa[nw1+7], 16'h01BE);
    check("drain_d7",    wd[nw1+7], 16'hE000);
    check("drain_ptr",   log_ptr, 8);
    check("drain_stall", stall_cpu, 0);
    check("ovf_sticky",  overflow, 1);

    // Reset in the middle of a pair write
    pc = 16'hE040; fetch = 1'b1; tick();
    pc = 16'hE080; tick(); fetch = 1'b0;
    check("mid_src",  log_wdata, 16'hE020);
    check("mid_aS",   log_addr,  16'h01C0);
    tick();
    check("mid_dst",  log_wdata, 16'hE040);
    check("mid_aD",   log_addr,  16'h01C2);
    puc_rst = 1'b1; tick();
    check("mrst_wr",   log_wr_en, 0);
    check("mrst_ptr",  log_ptr, 0);
    check("mrst_ovf",  overflow, 0);
    check("mrst_addr", log_addr, 16'h01B0);
    check("mrst_stl",  stall_cpu, 0);
    puc_rst = 1'b0;
    nw1 = nw;
    repeat (5) tick();
    check("mrst_fifo", nw - nw1, 0);
    fetch_wait(16'hC000);
    check("mrst_last", nw - nw1, 0);
    check("mrst_ptr2", log_ptr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
